// File: rtl/display_pkg.sv
// display_pkg: shared segment codes and scan state encoding for the hex display driver
package display_pkg;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   typedef enum logic {ST_SHOW, ST_GAP} state_t;
endpackage

// File: rtl/hex7seg.sv
// hex7seg: nibble to active-low {g,f,e,d,c,b,a} segment decoder
module hex7seg
   import display_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/display_scan_hex.sv
// display_scan_hex: multiplexed hex scanner with inter-digit gap, leading-zero blanking and blink
module display_scan_hex
   import display_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int DIV          = 50000,
   parameter int GAP          = 8,
   parameter int BLINK_FRAMES = 64,
   parameter int LZ_BLANK     = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   entrada,
   input  logic [DIGITS-1:0]     blink_mask,
   output logic [6:0]            saida,
   output logic [DIGITS-1:0]     anodo,
   output logic                  quadro
);
   localparam int MX = DIV > GAP ? DIV : GAP;
   localparam int CW = MX > 1 ? $clog2(MX) : 1;
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   state_t              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [FW-1:0]       frame_q, frame_d;
   logic                phase_q, phase_d;
   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic [6:0]          saida_q, saida_d;
   logic [DIGITS-1:0]   anodo_q, anodo_d;
   logic                quadro_q, quadro_d;
   logic [DIGITS-1:0]   lz;
   logic [3:0]          nib;
   logic [6:0]          seg;
   logic                slot_end, adv, wrap, blank, dark;
   hex7seg u_dec (.nib(nib), .seg(seg));
   // digit i (i>0) is a leading zero when every nibble from i upward is zero
   always_comb begin
      lz = '0;
      for (int i = 1; i < DIGITS; i++) lz[i] = (LZ_BLANK != 0) && ((shadow_q >> (4 * i)) == '0);
   end
   always_comb begin
      nib      = shadow_q[{idx_q, 2'b00} +: 4];
      blank    = lz[idx_q] | (phase_q & blink_mask[idx_q]);
      slot_end = state_q == ST_SHOW ? cnt_q == CW'(DIV - 1) : cnt_q == CW'(GAP > 0 ? GAP - 1 : 0);
      adv      = slot_end & (state_q == ST_GAP || GAP == 0);
      wrap     = adv & (idx_q == IW'(DIGITS - 1));
      dark     = !enable || state_q == ST_GAP;
      shadow_d = load ? entrada : shadow_q;
      state_d  = ST_SHOW;
      idx_d    = '0;
      cnt_d    = '0;
      frame_d  = frame_q;
      phase_d  = phase_q;
      if (enable) begin
         cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
         state_d = adv ? ST_SHOW : slot_end ? ST_GAP : state_q;
         idx_d   = adv ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
         if (wrap) begin
            frame_d = frame_q == FW'(BLINK_FRAMES - 1) ? '0 : frame_q + 1'b1;
            phase_d = phase_q ^ (frame_q == FW'(BLINK_FRAMES - 1));
         end
      end
      quadro_d = enable & wrap;
      anodo_d  = dark ? '1 : ~(DIGITS'(1) << idx_q);
      saida_d  = (dark || blank) ? SEG_BLANK : seg;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_SHOW;
         idx_q    <= '0;
         cnt_q    <= '0;
         frame_q  <= '0;
         phase_q  <= 1'b0;
         shadow_q <= '0;
         saida_q  <= SEG_BLANK;
         anodo_q  <= '1;
         quadro_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         frame_q  <= frame_d;
         phase_q  <= phase_d;
         shadow_q <= shadow_d;
         saida_q  <= saida_d;
         anodo_q  <= anodo_d;
         quadro_q <= quadro_d;
      end
   end
   assign saida  = saida_q;
   assign anodo  = anodo_q;
   assign quadro = quadro_q;
endmodule
